// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC parallel-bus transaction front-end.
package rtc_pkg;

  localparam int RTC_FRAME_LEN = 37;
  localparam int RTC_BUS_W     = 8;

  localparam logic OP_READ  = 1'b1;
  localparam logic OP_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } rtc_state_e;

endpackage

// File: rtl/rtc_strobe_sync.sv
// Two register stages on the generator strobes and AD input bus, plus the
// edge detectors the transaction FSM needs.
module rtc_strobe_sync
  import rtc_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cs_n_i,
  input  logic                 rd_n_i,
  input  logic                 wr_n_i,
  input  logic                 a_d_i,
  input  logic [RTC_BUS_W-1:0] ad_in_i,
  output logic                 cs_s_o,
  output logic                 rd_s_o,
  output logic                 wr_s_o,
  output logic                 a_d_s_o,
  output logic [RTC_BUS_W-1:0] ad_in_s_o,
  output logic                 cs_rise_o,
  output logic                 rd_rise_o,
  output logic                 a_d_rise_o,
  output logic                 a_d_fall_o
);

  logic                 cs_s_q, rd_s_q, wr_s_q, a_d_s_q;
  logic [RTC_BUS_W-1:0] ad_in_s_q;
  logic                 cs_q, rd_q, a_d_q;

  // Strobes are active low, so both stages reset to the inactive level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_s_q    <= 1'b1;
      rd_s_q    <= 1'b1;
      wr_s_q    <= 1'b1;
      a_d_s_q   <= 1'b1;
      ad_in_s_q <= '0;
      cs_q      <= 1'b1;
      rd_q      <= 1'b1;
      a_d_q     <= 1'b1;
    end else begin
      cs_s_q    <= cs_n_i;
      rd_s_q    <= rd_n_i;
      wr_s_q    <= wr_n_i;
      a_d_s_q   <= a_d_i;
      ad_in_s_q <= ad_in_i;
      cs_q      <= cs_s_q;
      rd_q      <= rd_s_q;
      a_d_q     <= a_d_s_q;
    end
  end

  assign cs_s_o    = cs_s_q;
  assign rd_s_o    = rd_s_q;
  assign wr_s_o    = wr_s_q;
  assign a_d_s_o   = a_d_s_q;
  assign ad_in_s_o = ad_in_s_q;

  assign cs_rise_o  = cs_s_q & ~cs_q;
  assign rd_rise_o  = rd_s_q & ~rd_q;
  assign a_d_rise_o = a_d_s_q & ~a_d_q;
  assign a_d_fall_o = ~a_d_s_q & a_d_q;

endmodule

// File: rtl/rtc_bus_interface.sv
// Single-byte read/write front-end that gates one generator strobe frame onto
// the RTC pins. Define RTC_TIMEOUT_EN to abort a stalled SYNC wait with err.
module rtc_bus_interface
  import rtc_pkg::*;
`ifdef RTC_TIMEOUT_EN
#(
  parameter int FRAME_TIMEOUT = 128
)
`endif
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cs_n,
  input  logic                 rd_n,
  input  logic                 wr_n,
  input  logic                 a_d,
  output logic                 op_read,
  input  logic                 req,
  input  logic                 req_write,
  input  logic [RTC_BUS_W-1:0] req_addr,
  input  logic [RTC_BUS_W-1:0] req_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [RTC_BUS_W-1:0] rdata,
  output logic [RTC_BUS_W-1:0] ad_out,
  output logic                 ad_oe,
  input  logic [RTC_BUS_W-1:0] ad_in,
  output logic                 rtc_cs_n,
  output logic                 rtc_rd_n,
  output logic                 rtc_wr_n,
  output logic                 rtc_ad
);

  rtc_state_e           state_q, state_d;
  logic [RTC_BUS_W-1:0] addr_q, addr_d;
  logic [RTC_BUS_W-1:0] wdata_q, wdata_d;
  logic [RTC_BUS_W-1:0] rdata_q, rdata_d;
  logic                 write_q, write_d;
  logic                 op_read_q, op_read_d;
  logic                 seen_cs_q, seen_cs_d;
  logic                 timeout;

  logic                 cs_s, rd_s, wr_s, a_d_s;
  logic [RTC_BUS_W-1:0] ad_in_s;
  logic                 cs_rise, rd_rise, a_d_rise, a_d_fall;

  rtc_strobe_sync u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .cs_n_i     (cs_n),
    .rd_n_i     (rd_n),
    .wr_n_i     (wr_n),
    .a_d_i      (a_d),
    .ad_in_i    (ad_in),
    .cs_s_o     (cs_s),
    .rd_s_o     (rd_s),
    .wr_s_o     (wr_s),
    .a_d_s_o    (a_d_s),
    .ad_in_s_o  (ad_in_s),
    .cs_rise_o  (cs_rise),
    .rd_rise_o  (rd_rise),
    .a_d_rise_o (a_d_rise),
    .a_d_fall_o (a_d_fall)
  );

`ifdef RTC_TIMEOUT_EN
  localparam int TO_W = $clog2(FRAME_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end

  always_comb begin
    to_cnt_d = '0;
    if (state_q == ST_SYNC) to_cnt_d = to_cnt_q + 1'b1;
  end

  assign timeout = (state_q == ST_SYNC) && (to_cnt_q == TO_W'(FRAME_TIMEOUT));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      op_read_q <= OP_WRITE;
      seen_cs_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      write_q   <= write_d;
      op_read_q <= op_read_d;
      seen_cs_q <= seen_cs_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    write_d   = write_q;
    op_read_d = op_read_q;
    seen_cs_d = seen_cs_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          write_d   = req_write;
          op_read_d = req_write ? OP_WRITE : OP_READ;
          state_d   = ST_SYNC;
        end
      end
      // Only a clean a_d fall with CS low counts, so a mid-frame request
      // sits out the rest of the current frame.
      ST_SYNC: begin
        if (a_d_fall && !cs_s) state_d = ST_ADDR;
        else if (timeout)      state_d = ST_IDLE;
      end
      ST_ADDR: begin
        if (a_d_rise) begin
          state_d   = ST_DATA;
          seen_cs_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (!cs_s) seen_cs_d = 1'b1;
        if (!write_q && rd_rise) rdata_d = ad_in_s;
        if (cs_rise && seen_cs_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rtc_cs_n = 1'b1;
    rtc_rd_n = 1'b1;
    rtc_wr_n = 1'b1;
    rtc_ad   = 1'b1;
    ad_out   = '0;
    ad_oe    = 1'b0;
    done     = 1'b0;
    busy     = (state_q != ST_IDLE);
    case (state_q)
      ST_ADDR: begin
        rtc_cs_n = cs_s;
        rtc_rd_n = rd_s;
        rtc_wr_n = wr_s;
        rtc_ad   = a_d_s;
        ad_out   = addr_q;
        ad_oe    = 1'b1;
      end
      ST_DATA: begin
        rtc_cs_n = cs_s;
        rtc_rd_n = rd_s;
        rtc_wr_n = wr_s;
        rtc_ad   = a_d_s;
        if (write_q && !cs_s) begin
          ad_out = wdata_q;
          ad_oe  = 1'b1;
        end
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign op_read = op_read_q;
  assign rdata   = rdata_q;
  assign err     = timeout;

endmodule

// File: tb/tb_rtc_bus_interface.sv
// Directed bench for rtc_bus_interface with a behavioural 37-cycle strobe
// generator and an RTC bus model that drives 0x37 while rtc_rd_n is low.
module tb_rtc_bus_interface;
  import rtc_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a_d = 1'b1;
  logic       req = 1'b0, req_write = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic [7:0] ad_in;
  logic       op_read, busy, done, err, ad_oe;
  logic [7:0] rdata, ad_out;
  logic       rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad;

  int checkCount = 0;
  int errorCount = 0;

  int   genCount = RTC_FRAME_LEN - 1;
  logic genMode  = 1'b0;
  logic stall    = 1'b0;

  int doneCount, latency, busyFirst, oeCycles, addrCycles, wdataCycles;
  int wrLow, rdLow, csLow, adLow, oeRdLow, preFrameLow, errCount;
  logic [7:0] rdataAtDone;

  rtc_bus_interface dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cs_n      (cs_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .a_d       (a_d),
    .op_read   (op_read),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .ad_out    (ad_out),
    .ad_oe     (ad_oe),
    .ad_in     (ad_in),
    .rtc_cs_n  (rtc_cs_n),
    .rtc_rd_n  (rtc_rd_n),
    .rtc_wr_n  (rtc_wr_n),
    .rtc_ad    (rtc_ad)
  );

  always #5 clk = ~clk;

  assign ad_in = (rtc_rd_n == 1'b0) ? 8'h37 : 8'hA5;

  // Generator: address phase at counts 0-9 (CS 0-8), data CS at 13-30,
  // RD or WR at 15-28 depending on the mode latched at count 0.
  initial begin
    forever begin
      @(negedge clk);
      if (stall) begin
        genCount = RTC_FRAME_LEN - 1;
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a_d = 1'b1;
      end else begin
        genCount = (genCount == RTC_FRAME_LEN - 1) ? 0 : genCount + 1;
        if (genCount == 0) genMode = op_read;
        a_d  = (genCount <= 9) ? 1'b0 : 1'b1;
        cs_n = ((genCount <= 8) || (genCount >= 13 && genCount <= 30)) ? 1'b0 : 1'b1;
        rd_n = (genMode && genCount >= 15 && genCount <= 28) ? 1'b0 : 1'b1;
        wr_n = (!genMode && genCount >= 15 && genCount <= 28) ? 1'b0 : 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic isWrite, input logic [7:0] addr, input logic [7:0] data,
                               input int startCount);
    bit found = 0;
    for (int i = 0; i < 2 * RTC_FRAME_LEN && !found; i++) begin
      @(posedge clk); #1;
      if (genCount == startCount) found = 1;
    end
    checkOutput("genAlign", 32'(found), 1);
    req_write = isWrite;
    req_addr  = addr;
    req_wdata = data;
    req       = 1'b1;
  endtask

  task automatic runTransaction(input logic isWrite, input logic [7:0] addr, input logic [7:0] data,
                                input int startCount, input int secondReqAt);
    bit waiting = 1;
    doneCount = 0; latency = 0; busyFirst = 0; oeCycles = 0; addrCycles = 0;
    wdataCycles = 0; wrLow = 0; rdLow = 0; csLow = 0; adLow = 0; oeRdLow = 0;
    preFrameLow = 0; errCount = 0; rdataAtDone = '0;
    applyStimulus(isWrite, addr, data, startCount);
    for (int i = 1; i <= 150; i++) begin
      @(posedge clk); #1;
      if (i == 1) busyFirst = int'(busy);
      req = (i == secondReqAt);
      if (i == secondReqAt) req_addr = 8'h55;
      if (waiting) begin
        if (genCount == 0) waiting = 0;
        else if (!rtc_cs_n || !rtc_rd_n || !rtc_wr_n || !rtc_ad) preFrameLow++;
      end
      if (done) begin
        doneCount++;
        if (doneCount == 1) begin
          latency = i;
          rdataAtDone = rdata;
        end
      end
      if (!rtc_cs_n) csLow++;
      if (!rtc_rd_n) rdLow++;
      if (!rtc_wr_n) wrLow++;
      if (!rtc_ad) adLow++;
      if (ad_oe) oeCycles++;
      if (ad_oe && ad_out == addr) addrCycles++;
      if (!rtc_wr_n && ad_oe && ad_out == data) wdataCycles++;
      if (ad_oe && !rtc_rd_n) oeRdLow++;
      if (err) errCount++;
    end
    req = 1'b0;
  endtask

  initial begin
    int found;
    int errAt;
    int busyCycles;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_rtc_cs_n", 32'(rtc_cs_n), 1);
    checkOutput("rst_rtc_rd_n", 32'(rtc_rd_n), 1);
    checkOutput("rst_rtc_wr_n", 32'(rtc_wr_n), 1);
    checkOutput("rst_rtc_ad", 32'(rtc_ad), 1);
    checkOutput("rst_ad_oe", 32'(ad_oe), 0);
    checkOutput("rst_ad_out", 32'(ad_out), 0);
    checkOutput("rst_op_read", 32'(op_read), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_rdata", 32'(rdata), 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] write 0x21 <- 0x45");
    runTransaction(1'b1, 8'h21, 8'h45, 20, 0);
    checkOutput("wr_busyRise", 32'(busyFirst), 1);
    checkOutput("wr_op_read", 32'(op_read), 0);
    checkOutput("wr_addrCycles", 32'(addrCycles), 10);
    checkOutput("wr_dataCycles", 32'(wdataCycles), 14);
    checkOutput("wr_oeCycles", 32'(oeCycles), 28);
    checkOutput("wr_wrLow", 32'(wrLow), 14);
    checkOutput("wr_rdLow", 32'(rdLow), 0);
    checkOutput("wr_csLow", 32'(csLow), 26);
    checkOutput("wr_adLow", 32'(adLow), 9);
    checkOutput("wr_preFrameLow", 32'(preFrameLow), 0);
    checkOutput("wr_doneCount", 32'(doneCount), 1);
    checkOutput("wr_latencyOk", 32'(latency >= 30 && latency <= 80), 1);
    checkOutput("wr_busyEnd", 32'(busy), 0);

    $display("[TB] read 0x22");
    runTransaction(1'b0, 8'h22, 8'h00, 20, 0);
    checkOutput("rd_op_read", 32'(op_read), 1);
    checkOutput("rd_addrCycles", 32'(addrCycles), 10);
    checkOutput("rd_oeCycles", 32'(oeCycles), 10);
    checkOutput("rd_oeWhileRdLow", 32'(oeRdLow), 0);
    checkOutput("rd_rdLow", 32'(rdLow), 14);
    checkOutput("rd_wrLow", 32'(wrLow), 0);
    checkOutput("rd_csLow", 32'(csLow), 26);
    checkOutput("rd_doneCount", 32'(doneCount), 1);
    checkOutput("rd_rdataAtDone", 32'(rdataAtDone), 32'h37);
    checkOutput("rd_latencyOk", 32'(latency >= 30 && latency <= 80), 1);

    $display("[TB] mid-frame write with second req while busy");
    runTransaction(1'b1, 8'h30, 8'h5A, 15, 10);
    checkOutput("mid_preFrameLow", 32'(preFrameLow), 0);
    checkOutput("mid_doneCount", 32'(doneCount), 1);
    checkOutput("mid_addrCycles", 32'(addrCycles), 10);
    checkOutput("mid_dataCycles", 32'(wdataCycles), 14);
    checkOutput("mid_latencyOk", 32'(latency >= 30 && latency <= 80), 1);
    checkOutput("mid_rdataHeld", 32'(rdata), 32'h37);

    $display("[TB] reset during DATA");
    applyStimulus(1'b1, 8'h66, 8'h77, 20);
    found = 0;
    for (int i = 1; i <= 100 && found == 0; i++) begin
      @(posedge clk); #1;
      req = 1'b0;
      if (!rtc_wr_n) found = 1;
    end
    req = 1'b0;
    checkOutput("rst_midDataReached", 32'(found), 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rstMid_rtc_cs_n", 32'(rtc_cs_n), 1);
    checkOutput("rstMid_rtc_wr_n", 32'(rtc_wr_n), 1);
    checkOutput("rstMid_rtc_ad", 32'(rtc_ad), 1);
    checkOutput("rstMid_ad_oe", 32'(ad_oe), 0);
    checkOutput("rstMid_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    runTransaction(1'b1, 8'h10, 8'h99, 20, 0);
    checkOutput("post_doneCount", 32'(doneCount), 1);
    checkOutput("post_addrCycles", 32'(addrCycles), 10);
    checkOutput("post_dataCycles", 32'(wdataCycles), 14);
    checkOutput("post_wrLow", 32'(wrLow), 14);

    $display("[TB] stalled generator");
    @(posedge clk); #1;
    stall = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    req_write = 1'b0;
    req_addr  = 8'h22;
    req       = 1'b1;
    errAt = 0; errCount = 0; doneCount = 0; busyCycles = 0;
`ifdef RTC_TIMEOUT_EN
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      req = 1'b0;
      if (err) begin
        errCount++;
        if (errAt == 0) errAt = i;
      end
      if (done) doneCount++;
      if (errAt != 0 && i == errAt + 1) checkOutput("to_busyAfterErr", 32'(busy), 0);
    end
    checkOutput("to_errCount", 32'(errCount), 1);
    checkOutput("to_errAtOk", 32'(errAt >= 128 && errAt <= 130), 1);
    checkOutput("to_doneCount", 32'(doneCount), 0);
    checkOutput("to_busyEnd", 32'(busy), 0);
`else
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk); #1;
      req = 1'b0;
      if (busy) busyCycles++;
      if (err) errCount++;
      if (done) doneCount++;
    end
    checkOutput("stall_busyCycles", 32'(busyCycles), 1000);
    checkOutput("stall_errCount", 32'(errCount), 0);
    checkOutput("stall_doneCount", 32'(doneCount), 0);
    stall = 1'b0;
    rdataAtDone = '0;
    for (int i = 1; i <= 150; i++) begin
      @(posedge clk); #1;
      if (done) begin
        doneCount++;
        rdataAtDone = rdata;
      end
    end
    checkOutput("resume_doneCount", 32'(doneCount), 1);
    checkOutput("resume_rdata", 32'(rdataAtDone), 32'h37);
    checkOutput("resume_busyEnd", 32'(busy), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/rtc_bus_interface.md
# rtc_bus_interface

Transaction front-end for the RTC parallel bus, directly downstream of the RTC strobe generator. It accepts a single-byte read or write request and sets the generator's mode input. It then gates the generator's CS/RD/WR/A-D strobes onto the RTC pins for exactly one strobe frame, drives or captures the multiplexed address/data bus, and returns read data with a done pulse.

## Interface
- `FRAME_TIMEOUT`, 128: clk cycles allowed in SYNC before abort; used only with `RTC_TIMEOUT_EN`.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cs_n`, `rd_n`, `wr_n`, `a_d` in 1 each: strobes from the generator. Active low; `a_d`=0 marks the address phase.
- `op_read` out 1: generator mode select; 1 = read frame, 0 = write frame.
- `req` in 1: start a transaction; sampled only in IDLE.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 8: RTC register address.
- `req_wdata` in 8: write data.
- `busy` out 1: high from acceptance until return to IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle timeout pulse; tied 0 without the macro.
- `rdata` out 8: last captured read byte.
- `ad_out` out 8, `ad_oe` out 1, `ad_in` in 8: AD bus halves; the tri-state buffer sits at top level.
- `rtc_cs_n`, `rtc_rd_n`, `rtc_wr_n`, `rtc_ad` out 1 each: gated strobes to the RTC pins.

## Operation
- Stage 1: input strobes and `ad_in` pass through one register stage (`*_s`); the strobe reset value is 1.
- Stage 2: a second register stage (`*_q`) feeds edge detection.
- Pin strobes equal the `*_s` values in ADDR and DATA. In every other state they are forced to 1.
- States: IDLE, SYNC, ADDR, DATA, DONE.
- IDLE:
  - On `req`, latch addr, wdata and direction; set `op_read` = !req_write; assert `busy`; go to SYNC.
- SYNC:
  - Wait for frame start: `a_d_q`=1, `a_d_s`=0 and `cs_s`=0. Then go to ADDR.
  - A request arriving mid-frame waits for the next frame; no pin activity occurs until then.
- ADDR:
  - `ad_out`=addr, `ad_oe`=1.
  - When `a_d_s` rises, go to DATA and clear `seen_cs`.
- DATA:
  - Set `seen_cs` when `cs_s`=0.
  - Write: `ad_out`=wdata and `ad_oe`=1 while `cs_s`=0; otherwise `ad_oe`=0.
  - Read: `ad_oe`=0 throughout; on a `rd_s` rising edge, load `rdata` from `ad_in_s`.
  - On a `cs_s` rising edge with `seen_cs`=1, go to DONE.
- DONE:
  - `done`=1 for one cycle, then go to IDLE with `busy`=0.
  - `rdata` is valid in this cycle and holds its value until the next read capture.
- `op_read` holds its value until the next acceptance.
- `req` while `busy` is ignored, not queued.

## Timing
- Reset values: `rtc_*`=1, `ad_oe`=0, `ad_out`=0, `op_read`=0, `busy`=0, `done`=0, `err`=0, `rdata`=0, state = IDLE.
- Reset mid-transaction takes effect immediately and asynchronously. The pins return to idle and the transaction is dropped.
- `busy` rises the cycle after `req` is sampled.
- Pin strobes lag the generator by one clk.
- Frame length is 37 clk cycles. `done` lags `req` by 30 to 80 cycles.
- `ad_oe` is never 1 while the registered `rd_s`=0.

## Configuration
- Macro `RTC_TIMEOUT_EN`, defined:
  - A SYNC-state counter of `$clog2(FRAME_TIMEOUT+1)` bits is instantiated.
  - When the counter reaches `FRAME_TIMEOUT`, pulse `err`, return to IDLE and clear `busy`. `done` is not asserted.
- Undefined:
  - No counter; `err` is tied to 0.
  - SYNC waits indefinitely.

## Structure
- Package `rtc_pkg` holds:
  - the state enum;
  - `RTC_FRAME_LEN`=37;
  - `RTC_BUS_W`=8;
  - the `op_read` encoding constants.
- Sub-module `rtc_strobe_sync` contains both register stages and the rise/fall detectors for `cs_n`, `rd_n` and `a_d`.

## Test plan
- Write, addr 0x21 / data 0x45:
  - ADDR: `ad_out`=0x21, `ad_oe`=1.
  - DATA window: `ad_out`=0x45 and `rtc_wr_n` pulses low.
  - `op_read`=0, `rtc_rd_n` stays 1, exactly one `done`.
- Read, addr 0x22, bus model drives 0x37 while `rtc_rd_n`=0:
  - `ad_oe`=0 in DATA, `rdata`=0x37 at `done`, `op_read`=1.
- `req` issued at generator count 15:
  - Pins stay 1 until the next frame start.
  - A second `req` during `busy` produces no extra `done`.
- Assert `reset_n`=0 mid-DATA:
  - Same cycle: `rtc_*`=1, `ad_oe`=0, `busy`=0.
  - After release, a new write completes normally.
- Stall the generator with all strobes held at 1:
  - With `RTC_TIMEOUT_EN`: `err` pulses after 128 SYNC cycles and `busy`=0.
  - Without it: `busy` stays 1 for 1000 cycles.
